exibicao_multibase: RTL and testbench

Display stage placed directly downstream of the result register in the RPN calculator top level. It takes the registered 8-bit result and the 2-bit base selector (SW[9:8]). It converts the value with a multi-cycle shift-add-3 (double-dabble) engine and drives the six 7-segment displays HEX0..HEX5. Outputs are registered and change only on conversion completion, so the displays never show partial digits.

---
 rtl/exibicao_multibase.sv | 227 ++++++++++++++++++++++
 tb/tb_exibicao_multibase.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/exibicao_multibase.sv
// Purpose : converts the registered 8-bit calculator result to decimal, hex,
//           octal or signed decimal and drives six 7-segment displays.
// Latency : 9 clock edges from the IDLE edge that samples a change (capture,
//           8 double-dabble iterations, display update).
// Backpressure: none. Inputs that change mid-conversion are picked up by the
//           next conversion, so the displays never show a mix of two values.
//
// Ports:
//   clk        system clock (CLOCK_50)
//   reset      asynchronous, active-high
//   resultado  value to display
//   base       00 unsigned dec, 01 hex, 10 octal, 11 signed dec
//   HEX0..HEX2 digits (units .. third), HEX3 sign, HEX4 blank, HEX5 base letter
//   ocupado    high while a conversion is in flight
//
// Build option: define EXIBICAO_ZERO_BLANK_EN to blank leading zero digits
// on HEX2/HEX1. HEX0 always shows a digit.
module exibicao_multibase #(
  parameter bit SEG_ATIVO_BAIXO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] resultado,
  input  logic [1:0] base,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       ocupado
);

`ifdef EXIBICAO_ZERO_BLANK_EN
  localparam bit ZERO_BLANK = 1'b1;
`else
  localparam bit ZERO_BLANK = 1'b0;
`endif

  // Active-low reference patterns; pol() flips them for active-high boards.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_O     = 7'b0100011;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] BLANK_OUT = SEG_ATIVO_BAIXO ? SEG_BLANK : ~SEG_BLANK;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  function automatic logic [6:0] pol(input logic [6:0] s);
    return SEG_ATIVO_BAIXO ? s : ~s;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  state_t           state_q, state_d;
  logic             valido_q, valido_d;
  logic             ocupado_q, ocupado_d;
  logic [9:0]       last_q, last_d;     // {resultado, base} currently displayed
  logic [9:0]       cap_q, cap_d;       // {resultado, base} being converted
  logic [7:0]       op_q, op_d;         // magnitude being converted
  logic             neg_q, neg_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [19:0]      dd_q, dd_d;         // [19:8] BCD, [7:0] binary
  logic [5:0][6:0]  hex_q, hex_d;

  logic             start;
  logic [19:0]      dd_adj;
  logic [3:0]       dig2, dig1, dig0;
  logic             blank2, blank1;
  logic             sign_neg;
  logic [7:0]       op_in;

  assign start    = !valido_q || ({resultado, base} != last_q);
  assign sign_neg = (base == 2'b11) && resultado[7];
  // Two's-complement negate; 8'h80 maps to itself, which reads as 128.
  assign op_in    = sign_neg ? (~resultado + 8'd1) : resultado;

  // State register together with the datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      valido_q  <= 1'b0;
      ocupado_q <= 1'b0;
      last_q    <= '0;
      cap_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      dd_q      <= '0;
      hex_q     <= {6{BLANK_OUT}};
    end else begin
      state_q   <= state_d;
      valido_q  <= valido_d;
      ocupado_q <= ocupado_d;
      last_q    <= last_d;
      cap_q     <= cap_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      dd_q      <= dd_d;
      hex_q     <= hex_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONV;
      CONV:    if (cnt_q == 3'd7) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Double-dabble step: correct each BCD nibble, the shift happens below.
  always_comb begin
    dd_adj = {add3(dd_q[19:16]), add3(dd_q[15:12]), add3(dd_q[11:8]), dd_q[7:0]};
  end

  // Digit selection for the display update.
  always_comb begin
    dig2   = dd_q[19:16];
    dig1   = dd_q[15:12];
    dig0   = dd_q[11:8];
    blank2 = 1'b0;
    case (cap_q[1:0])
      2'b01: begin
        dig2   = 4'd0;
        dig1   = op_q[7:4];
        dig0   = op_q[3:0];
        blank2 = 1'b1;
      end
      2'b10: begin
        dig2 = {2'b00, op_q[7:6]};
        dig1 = {1'b0, op_q[5:3]};
        dig0 = {1'b0, op_q[2:0]};
      end
      default: ;
    endcase
    // A tens/middle digit is only leading when everything above it is zero.
    if (ZERO_BLANK && dig2 == 4'd0) blank2 = 1'b1;
    blank1 = ZERO_BLANK && (dig2 == 4'd0) && (dig1 == 4'd0);
  end

  // Output / datapath logic.
  always_comb begin
    valido_d  = valido_q;
    ocupado_d = ocupado_q;
    last_d    = last_q;
    cap_d     = cap_q;
    op_d      = op_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    dd_d      = dd_q;
    hex_d     = hex_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cap_d     = {resultado, base};
          op_d      = op_in;
          neg_d     = sign_neg;
          cnt_d     = 3'd0;
          dd_d      = {12'd0, op_in};
          ocupado_d = 1'b1;
        end
      end
      CONV: begin
        dd_d  = {dd_adj[18:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
      end
      UPDATE: begin
        hex_d[0] = pol(hex7(dig0));
        hex_d[1] = blank1 ? pol(SEG_BLANK) : pol(hex7(dig1));
        hex_d[2] = blank2 ? pol(SEG_BLANK) : pol(hex7(dig2));
        hex_d[3] = neg_q ? pol(SEG_MINUS) : pol(SEG_BLANK);
        hex_d[4] = pol(SEG_BLANK);
        case (cap_q[1:0])
          2'b00:   hex_d[5] = pol(SEG_D);
          2'b01:   hex_d[5] = pol(SEG_H);
          2'b10:   hex_d[5] = pol(SEG_O);
          default: hex_d[5] = pol(SEG_S);
        endcase
        last_d    = cap_q;
        valido_d  = 1'b1;
        ocupado_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign HEX0    = hex_q[0];
  assign HEX1    = hex_q[1];
  assign HEX2    = hex_q[2];
  assign HEX3    = hex_q[3];
  assign HEX4    = hex_q[4];
  assign HEX5    = hex_q[5];
  assign ocupado = ocupado_q;

endmodule

// File: tb/tb_exibicao_multibase.sv
// Purpose : self-checking bench for exibicao_multibase (active-low build).
// Latency : expects ocupado high for exactly 9 sampled cycles per conversion.
// Backpressure: n/a; expected displays queue up as stimulus is applied.
module tb_exibicao_multibase;

  typedef logic [5:0][6:0] disp_t;

  logic       clk;
  logic       reset;
  logic [7:0] resultado;
  logic [1:0] base;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       ocupado;

  int    n_checks = 0;
  int    n_fail   = 0;
  disp_t sb_q[$];
  disp_t last_exp;

  localparam logic [6:0] B_BLANK = 7'b1111111;

  exibicao_multibase #(.SEG_ATIVO_BAIXO(1'b1)) dut (
    .clk(clk), .reset(reset), .resultado(resultado), .base(base),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
    .ocupado(ocupado)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    logic [6:0] t[16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[d];
  endfunction

  function automatic disp_t model(input logic [7:0] r, input logic [1:0] b);
    disp_t e;
    int    v, d2, d1, d0;
    bit    neg, bl2, bl1;
    neg = (b == 2'b11) && r[7];
    v   = neg ? 256 - int'(r) : int'(r);
    bl2 = 1'b0;
    bl1 = 1'b0;
    case (b)
      2'b01: begin d2 = 0; d1 = v / 16; d0 = v % 16; bl2 = 1'b1; end
      2'b10: begin d2 = v / 64; d1 = (v / 8) % 8; d0 = v % 8; end
      default: begin d2 = v / 100; d1 = (v / 10) % 10; d0 = v % 10; end
    endcase
`ifdef EXIBICAO_ZERO_BLANK_EN
    if (d2 == 0) bl2 = 1'b1;
    if (d2 == 0 && d1 == 0) bl1 = 1'b1;
`endif
    e[0] = seg(d0);
    e[1] = bl1 ? B_BLANK : seg(d1);
    e[2] = bl2 ? B_BLANK : seg(d2);
    e[3] = neg ? 7'b0111111 : B_BLANK;
    e[4] = B_BLANK;
    case (b)
      2'b00:   e[5] = 7'b0100001;
      2'b01:   e[5] = 7'b0001001;
      2'b10:   e[5] = 7'b0100011;
      default: e[5] = 7'b0010010;
    endcase
    return e;
  endfunction

  function automatic disp_t observed();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic compare_disp(input string tag, input disp_t e);
    disp_t o;
    o = observed();
    for (int i = 0; i < 6; i++)
      check($sformatf("%s.HEX%0d", tag, i), 32'(o[i]), 32'(e[i]));
  endtask

  task automatic drive(input logic [7:0] r, input logic [1:0] b);
    resultado = r;
    base      = b;
    sb_q.push_back(model(r, b));
  endtask

  // Counts sampled ocupado-high cycles until it drops, then scores the display.
  task automatic finish_one(input string tag, input int exp_hi);
    int    hi;
    bit    done;
    disp_t e;
    hi   = 0;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (ocupado) hi++;
      else if (hi > 0) done = 1'b1;
    end
    check({tag, ".done"}, 32'(done), 32'd1);
    if (exp_hi >= 0) check({tag, ".latency"}, 32'(hi), 32'(exp_hi));
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      compare_disp(tag, e);
      last_exp = e;
    end
  endtask

  initial begin
    logic [7:0] r;
    logic [1:0] b;
    reset     = 1'b0;
    resultado = 8'd0;
    base      = 2'b00;
    #1 reset  = 1'b1;
    @(negedge clk);
    compare_disp("reset", {6{B_BLANK}});
    check("reset.ocupado", 32'(ocupado), 32'd0);

    // First conversion is forced after reset even though inputs are stable.
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(model(8'd0, 2'b00));
    finish_one("zero_dec", 9);

    repeat (3) @(negedge clk);
    check("idle_stable.ocupado", 32'(ocupado), 32'd0);

    drive(8'hFF, 2'b00); finish_one("ff_dec", 9);
    drive(8'hFF, 2'b01); finish_one("ff_hex", 9);
    drive(8'hFF, 2'b10); finish_one("ff_oct", 9);
    drive(8'h80, 2'b11); finish_one("s_m128", 9);
    drive(8'h7F, 2'b11); finish_one("s_127", 9);
    drive(8'hFF, 2'b11); finish_one("s_m1", 9);

    // Change inputs three edges into CONV: old value first, then the new one.
    drive(8'd42, 2'b00);
    repeat (4) @(negedge clk);
    compare_disp("no_tear", last_exp);
    drive(8'd99, 2'b00);
    finish_one("mid_42", 5);
    finish_one("mid_99", 9);

    // Reset after four iterations clears everything immediately.
    drive(8'hC8, 2'b11);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    compare_disp("async_rst", {6{B_BLANK}});
    check("async_rst.ocupado", 32'(ocupado), 32'd0);
    void'(sb_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(model(8'hC8, 2'b11));
    finish_one("after_rst", 9);

    for (int k = 0; k < 6; k++) begin
      do begin
        r = 8'($urandom_range(0, 255));
        b = 2'($urandom_range(0, 3));
      end while ({r, b} == {resultado, base});
      drive(r, b);
      finish_one($sformatf("rand%0d", k), 9);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
